// File: rtl/msk_demux_pipe_pkg.sv
// msk_demux_pipe_pkg
//   Shared definitions for the masked 1-to-2 demultiplexer.
//   - word_width(): masked bus width (count bits x d shares), using the same
//     share layout as the other masked gadgets.
//   - slot_state_e: output slot state encoding (EMPTY = 0, FULL = 1).
package msk_demux_pipe_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic int word_width(input int count, input int d);
    return count * d;
  endfunction

endpackage

// File: rtl/msk_demux_slot.sv
// msk_demux_slot
//   One-deep registered buffer for a masked word, with a load/drain handshake.
//   Shares are only stored and forwarded, never combined.
//   Optional build macro: MSK_DEMUX_CLEAR_ON_DRAIN_EN. When it is defined, a
//   slot that empties also zeroes its data register so consumed shares do not
//   linger on the output bus.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load_i          write data_i this cycle (caller only asserts when accept_o)
//   data_i          masked word to store
//   ready_i         downstream consumer accepts the held word
//   accept_o        slot can take a word this cycle (empty or draining)
//   valid_o         slot holds a word (registered)
//   data_o          held masked word (registered)
//
// state      | meaning
// -----------+-------------------------------------------
// SLOT_EMPTY | no word held, valid_o = 0
// SLOT_FULL  | word held in data_q, valid_o = 1
module msk_demux_slot
  import msk_demux_pipe_pkg::*;
#(
  parameter int d     = 1,
  parameter int count = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_i,
  input  logic [word_width(count, d)-1:0]  data_i,
  input  logic                             ready_i,
  output logic                             accept_o,
  output logic                             valid_o,
  output logic [word_width(count, d)-1:0]  data_o
);

  localparam int W = word_width(count, d);

  slot_state_e    state_q, state_d;
  logic [W-1:0]   data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          // drain and refill in the same cycle: stays FULL
          data_d = data_i;
        end else if (ready_i) begin
          state_d = SLOT_EMPTY;
`ifdef MSK_DEMUX_CLEAR_ON_DRAIN_EN
          data_d  = '0;
`else
          data_d  = data_q;
`endif
        end
      end
    endcase
  end

  assign valid_o  = (state_q == SLOT_FULL);
  assign data_o   = data_q;
  assign accept_o = (state_q == SLOT_EMPTY) || ready_i;

endmodule

// File: rtl/msk_demux_pipe.sv
// msk_demux_pipe
//   Registered 1-to-2 demultiplexer for masked share buses. One input word is
//   steered to the true or false channel by a non-sensitive select; each
//   channel has a one-deep output slot with valid/ready. Outputs come only
//   from slot registers. Optional build macro: MSK_DEMUX_CLEAR_ON_DRAIN_EN
//   (see msk_demux_slot).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid, in_ready, in_sel       input handshake and route select
//   in_data                          masked input word (count*d bits)
//   out_true_valid/ready/data        true channel (in_sel = 1)
//   out_false_valid/ready/data       false channel (in_sel = 0)
module msk_demux_pipe
  import msk_demux_pipe_pkg::*;
#(
  parameter int d     = 1,
  parameter int count = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sel,
  input  logic [word_width(count, d)-1:0]  in_data,
  output logic                             out_true_valid,
  input  logic                             out_true_ready,
  output logic [word_width(count, d)-1:0]  out_true_data,
  output logic                             out_false_valid,
  input  logic                             out_false_ready,
  output logic [word_width(count, d)-1:0]  out_false_data
);

  logic true_accept, false_accept;
  logic load_true, load_false;

  // in_ready only looks at the selected slot, so back-pressure on one
  // channel never stalls words routed to the other one
  assign in_ready   = in_sel ? true_accept : false_accept;
  assign load_true  = in_valid & in_ready & in_sel;
  assign load_false = in_valid & in_ready & ~in_sel;

  msk_demux_slot #(.d(d), .count(count)) u_slot_true (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_true),
    .data_i   (in_data),
    .ready_i  (out_true_ready),
    .accept_o (true_accept),
    .valid_o  (out_true_valid),
    .data_o   (out_true_data)
  );

  msk_demux_slot #(.d(d), .count(count)) u_slot_false (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_false),
    .data_i   (in_data),
    .ready_i  (out_false_ready),
    .accept_o (false_accept),
    .valid_o  (out_false_valid),
    .data_o   (out_false_data)
  );

endmodule

// File: tb/tb_msk_demux_pipe.sv
module tb_msk_demux_pipe;

  localparam int D = 2;
  localparam int COUNT = 8;
  localparam int W = D * COUNT;
`ifdef MSK_DEMUX_CLEAR_ON_DRAIN_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sel = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_true_valid, out_false_valid;
  logic         out_true_ready = 1'b1, out_false_ready = 1'b1;
  logic [W-1:0] out_true_data, out_false_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msk_demux_pipe #(.d(D), .count(COUNT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_sel          (in_sel),
    .in_data         (in_data),
    .out_true_valid  (out_true_valid),
    .out_true_ready  (out_true_ready),
    .out_true_data   (out_true_data),
    .out_false_valid (out_false_valid),
    .out_false_ready (out_false_ready),
    .out_false_data  (out_false_data)
  );

  typedef struct {
    logic         v;
    logic         sel;
    logic [W-1:0] data;
    logic         tr;
    logic         fr;
    logic         e_rdy;
    logic         e_tv;
    logic [W-1:0] e_td;
    logic         e_fv;
    logic [W-1:0] e_fd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic tv, input logic [W-1:0] td,
                          input logic fv, input logic [W-1:0] fd);
    chk({tag, ".true_valid"},  32'(out_true_valid),  32'(tv));
    chk({tag, ".true_data"},   32'(out_true_data),   32'(td));
    chk({tag, ".false_valid"}, 32'(out_false_valid), 32'(fv));
    chk({tag, ".false_data"},  32'(out_false_data),  32'(fd));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    cycle();
  endtask

  // behavioural model: each channel is a capacity-1 FIFO; the visible data
  // while empty is whatever was last held (or zero in the clearing build)
  logic [W-1:0] mq_t[$], mq_f[$];
  logic [W-1:0] hold_t, hold_f;

  initial begin
    logic [W-1:0] alt_words[8];
    logic exp_rdy;
    bit   dr_t, dr_f;

    vecs[0] = '{1, 1, 16'hA55A, 1, 1, 1, 1, 16'hA55A, 0, 16'h0000};
    vecs[1] = '{0, 0, 16'h0000, 1, 1, 1, 0, CLR ? 16'h0 : 16'hA55A, 0, 16'h0000};
    vecs[2] = '{1, 1, 16'h1234, 0, 1, 1, 1, 16'h1234, 0, 16'h0000};
    vecs[3] = '{1, 1, 16'h5678, 0, 1, 0, 1, 16'h1234, 0, 16'h0000};
    vecs[4] = '{1, 0, 16'h00FF, 0, 1, 1, 1, 16'h1234, 1, 16'h00FF};
    vecs[5] = '{1, 0, 16'hFF00, 0, 1, 1, 1, 16'h1234, 1, 16'hFF00};
    vecs[6] = '{1, 1, 16'hBEEF, 1, 1, 1, 1, 16'hBEEF, 0, CLR ? 16'h0 : 16'hFF00};
    vecs[7] = '{0, 0, 16'h0000, 1, 1, 1, 0, CLR ? 16'h0 : 16'hBEEF, 0, CLR ? 16'h0 : 16'hFF00};

    // reset state
    #12 rst_n = 1'b1;
    cycle();
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk_outs("reset", 0, 16'h0, 0, 16'h0);

    // directed table: routed word, back-pressure isolation, drain-and-refill
    for (int i = 0; i < 8; i++) begin
      in_valid = vecs[i].v;
      in_sel = vecs[i].sel;
      in_data = vecs[i].data;
      out_true_ready = vecs[i].tr;
      out_false_ready = vecs[i].fr;
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      cycle();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_tv, vecs[i].e_td, vecs[i].e_fv, vecs[i].e_fd);
    end

    // full-throughput alternation
    do_reset();
    out_true_ready = 1'b1;
    out_false_ready = 1'b1;
    for (int i = 0; i < 8; i++) alt_words[i] = W'(16'h1100 + 16'(i * 16'h0111));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel = i[0];
      in_data = alt_words[i];
      #1;
      chk($sformatf("alt%0d.in_ready", i), 32'(in_ready), 32'd1);
      cycle();
      if (i[0]) begin
        chk($sformatf("alt%0d.true_valid", i), 32'(out_true_valid), 32'd1);
        chk($sformatf("alt%0d.true_data", i), 32'(out_true_data), 32'(alt_words[i]));
      end else begin
        chk($sformatf("alt%0d.false_valid", i), 32'(out_false_valid), 32'd1);
        chk($sformatf("alt%0d.false_data", i), 32'(out_false_data), 32'(alt_words[i]));
      end
    end
    in_valid = 1'b0;

    // async reset mid-burst with both slots full
    do_reset();
    out_true_ready = 1'b0;
    out_false_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hC0DE;
    cycle();
    in_sel = 1'b0; in_data = 16'hFACE;
    cycle();
    in_valid = 1'b0;
    chk_outs("prerst", 1, 16'hC0DE, 1, 16'hFACE);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("midrst", 0, 16'h0, 0, 16'h0);
    #3 rst_n = 1'b1;
    out_true_ready = 1'b1;
    out_false_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("postrst%0d.valids", i), 32'({out_true_valid, out_false_valid}), 32'd0);
    end

    // randomized run against the model
    do_reset();
    mq_t.delete(); mq_f.delete();
    hold_t = '0; hold_f = '0;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_sel = 1'($urandom);
      in_data = W'($urandom);
      out_true_ready = 1'($urandom_range(0, 2) != 0);
      out_false_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = in_sel ? (mq_t.size() == 0 || out_true_ready)
                       : (mq_f.size() == 0 || out_false_ready);
      chk("rnd.in_ready", 32'(in_ready), 32'(exp_rdy));
      dr_t = (mq_t.size() != 0) && out_true_ready;
      dr_f = (mq_f.size() != 0) && out_false_ready;
      if (dr_t) void'(mq_t.pop_front());
      if (dr_f) void'(mq_f.pop_front());
      if (dr_t && CLR) hold_t = '0;
      if (dr_f && CLR) hold_f = '0;
      if (in_valid && exp_rdy) begin
        if (in_sel) begin mq_t.push_back(in_data); hold_t = in_data; end
        else        begin mq_f.push_back(in_data); hold_f = in_data; end
      end
      cycle();
      chk_outs("rnd", mq_t.size() != 0, hold_t, mq_f.size() != 0, hold_f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
